// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - counter types, default raster timing and sync clamp helper
package video_timing_pkg;

    localparam int HCNT_W = 9;
    localparam int VCNT_W = 9;

    typedef logic [HCNT_W-1:0] hcnt_t;
    typedef logic [VCNT_W-1:0] vcnt_t;

    localparam int DEF_H_TOTAL    = 384;
    localparam int DEF_H_ACTIVE   = 256;
    localparam int DEF_H_ACT_BEG  = 16;
    localparam int DEF_H_SYNC_BEG = 288;
    localparam int DEF_H_SYNC_LEN = 32;
    localparam int DEF_V_TOTAL    = 264;
    localparam int DEF_V_ACTIVE   = 224;
    localparam int DEF_V_SYNC_BEG = 232;
    localparam int DEF_V_SYNC_LEN = 4;
    localparam int DEF_H_STEP     = 2;
    localparam int DEF_V_STEP     = 2;
    localparam int DEF_HOFF_W     = 5;
    localparam int DEF_VOFF_W     = 3;
    localparam int DEF_RGB_W      = 12;

    // Signed sync start, held inside [lo, hi] so the pulse never touches active video or wraps
    function automatic int clamp_sync(input int nominal, input int off, input int step,
                                      input int lo, input int hi);
        int b;
        b = nominal + off * step;
        if (b < lo) begin
            b = lo;
        end else if (b > hi) begin
            b = hi;
        end
        return b;
    endfunction

endpackage

// File: rtl/vtg_sync_window.sv
// rtl/vtg_sync_window.sv - clamped sync window decode for one raster axis
module vtg_sync_window
    import video_timing_pkg::*;
#(
    parameter int CNT_W   = 9,
    parameter int NOMINAL = 288,
    parameter int STEP    = 2,
    parameter int LO      = 272,
    parameter int HI      = 352,
    parameter int LEN     = 32,
    parameter int OFF_W   = 5
) (
    input  logic [CNT_W-1:0]        cnt,
    input  logic signed [OFF_W-1:0] off,
    output logic                    sync_n
);

    logic [CNT_W-1:0] beg;

    assign beg    = CNT_W'(clamp_sync(NOMINAL, int'(off), STEP, LO, HI));
    assign sync_n = !((cnt >= beg) && (cnt < beg + CNT_W'(LEN)));

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with offset syncs; VTG_INTERLACE_EN adds f1 and odd-length frames
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_TOTAL    = DEF_H_TOTAL,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_ACT_BEG  = DEF_H_ACT_BEG,
    parameter int H_SYNC_BEG = DEF_H_SYNC_BEG,
    parameter int H_SYNC_LEN = DEF_H_SYNC_LEN,
    parameter int V_TOTAL    = DEF_V_TOTAL,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_SYNC_BEG = DEF_V_SYNC_BEG,
    parameter int V_SYNC_LEN = DEF_V_SYNC_LEN,
    parameter int H_STEP     = DEF_H_STEP,
    parameter int V_STEP     = DEF_V_STEP,
    parameter int HOFF_W     = DEF_HOFF_W,
    parameter int VOFF_W     = DEF_VOFF_W,
    parameter int RGB_W      = DEF_RGB_W
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     ce,
    input  logic signed [HOFF_W-1:0] hoffs,
    input  logic signed [VOFF_W-1:0] voffs,
    input  logic [RGB_W-1:0]         core_rgb,
    output logic [8:0]               hpos,
    output logic [8:0]               vpos,
    output logic [RGB_W-1:0]         rgb,
    output logic                     hblk,
    output logic                     vblk,
    output logic                     hsyn,
    output logic                     vsyn,
    output logic                     de,
`ifdef VTG_INTERLACE_EN
    output logic                     f1,
`endif
    output logic                     frame_start
);

    hcnt_t                    hcnt;
    vcnt_t                    vcnt;
    vcnt_t                    vwin_cnt;
    logic signed [HOFF_W-1:0] hoffs_l;
    logic signed [VOFF_W-1:0] voffs_l;
    logic                     h_last;
    logic                     v_last;
    logic                     frame_last;
    logic                     hblk_nx;
    logic                     vblk_nx;
    logic                     hsyn_nx;
    logic                     vsyn_nx;

    assign h_last = (hcnt == hcnt_t'(H_TOTAL - 1));

`ifdef VTG_INTERLACE_EN
    // Odd field carries one extra line; its vsync is shifted by half a line by
    // treating the first half of each line as belonging to the previous line.
    assign v_last   = (vcnt == (f1 ? vcnt_t'(V_TOTAL) : vcnt_t'(V_TOTAL - 1)));
    assign vwin_cnt = (f1 && (hcnt < hcnt_t'(H_TOTAL / 2))) ? vcnt - vcnt_t'(1) : vcnt;
`else
    assign v_last   = (vcnt == vcnt_t'(V_TOTAL - 1));
    assign vwin_cnt = vcnt;
`endif

    assign frame_last = h_last && v_last;

    assign hpos = 9'(hcnt - hcnt_t'(H_ACT_BEG));
    assign vpos = 9'(vcnt);

    assign hblk_nx = !((hcnt >= hcnt_t'(H_ACT_BEG)) && (hcnt < hcnt_t'(H_ACT_BEG + H_ACTIVE)));
    assign vblk_nx = !(vcnt < vcnt_t'(V_ACTIVE));

    vtg_sync_window #(
        .CNT_W   (HCNT_W),
        .NOMINAL (H_SYNC_BEG),
        .STEP    (H_STEP),
        .LO      (H_ACT_BEG + H_ACTIVE),
        .HI      (H_TOTAL - H_SYNC_LEN),
        .LEN     (H_SYNC_LEN),
        .OFF_W   (HOFF_W)
    ) u_hsync (
        .cnt    (hcnt),
        .off    (hoffs_l),
        .sync_n (hsyn_nx)
    );

    vtg_sync_window #(
        .CNT_W   (VCNT_W),
        .NOMINAL (V_SYNC_BEG),
        .STEP    (V_STEP),
        .LO      (V_ACTIVE),
        .HI      (V_TOTAL - V_SYNC_LEN),
        .LEN     (V_SYNC_LEN),
        .OFF_W   (VOFF_W)
    ) u_vsync (
        .cnt    (vwin_cnt),
        .off    (voffs_l),
        .sync_n (vsyn_nx)
    );

    // Raster counters plus offset capture on the last pixel of each frame
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            hcnt    <= '0;
            vcnt    <= '0;
            hoffs_l <= '0;
            voffs_l <= '0;
        end else if (ce) begin
            hcnt <= h_last ? '0 : hcnt + hcnt_t'(1);
            if (h_last) begin
                vcnt <= v_last ? '0 : vcnt + vcnt_t'(1);
            end
            if (frame_last) begin
                hoffs_l <= hoffs;
                voffs_l <= voffs;
            end
        end
    end

`ifdef VTG_INTERLACE_EN
    // Field flag flips on every frame wrap
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            f1 <= 1'b0;
        end else if (ce && frame_last) begin
            f1 <= !f1;
        end
    end
`endif

    // Registered video outputs, one pixel behind hpos/vpos and mutually aligned
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            hblk        <= 1'b1;
            vblk        <= 1'b1;
            hsyn        <= 1'b1;
            vsyn        <= 1'b1;
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else if (ce) begin
            hblk        <= hblk_nx;
            vblk        <= vblk_nx;
            hsyn        <= hsyn_nx;
            vsyn        <= vsyn_nx;
            de          <= !(hblk_nx || vblk_nx);
            rgb         <= (hblk_nx || vblk_nx) ? '0 : core_rgb;
            frame_start <= (hcnt == '0) && (vcnt == '0);
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized self-checking bench for video_timing_gen
module tb_video_timing_gen;

    localparam int HT  = 384;
    localparam int HA  = 256;
    localparam int HAB = 16;
    localparam int HSB = 288;
    localparam int HSL = 32;
    localparam int VT  = 16;
    localparam int VA  = 8;
    localparam int VSB = 10;
    localparam int VSL = 2;
    localparam int HST = 2;
    localparam int VST = 2;
    localparam int HOW = 5;
    localparam int VOW = 3;
    localparam int RW  = 12;
    localparam int FR  = HT * VT;

    logic                  clk_sys = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  ce = 1'b0;
    logic signed [HOW-1:0] hoffs = '0;
    logic signed [VOW-1:0] voffs = '0;
    logic [RW-1:0]         core_rgb = '0;
    logic [8:0]            hpos;
    logic [8:0]            vpos;
    logic [RW-1:0]         rgb;
    logic                  hblk, vblk, hsyn, vsyn, de, frame_start;
`ifdef VTG_INTERLACE_EN
    logic                  f1;
`endif

    video_timing_gen #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_ACT_BEG(HAB), .H_SYNC_BEG(HSB), .H_SYNC_LEN(HSL),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_BEG(VSB), .V_SYNC_LEN(VSL),
        .H_STEP(HST), .V_STEP(VST), .HOFF_W(HOW), .VOFF_W(VOW), .RGB_W(RW)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ce          (ce),
        .hoffs       (hoffs),
        .voffs       (voffs),
        .core_rgb    (core_rgb),
        .hpos        (hpos),
        .vpos        (vpos),
        .rgb         (rgb),
        .hblk        (hblk),
        .vblk        (vblk),
        .hsyn        (hsyn),
        .vsyn        (vsyn),
        .de          (de),
`ifdef VTG_INTERLACE_EN
        .f1          (f1),
`endif
        .frame_start (frame_start)
    );

    always #5 clk_sys = ~clk_sys;

    int n_pass = 0;
    int n_total = 0;

    // reference position (pixel/line the counters point at), field and latched offsets
    int mh = 0, mv = 0, mf1 = 0, hl = 0, vl = 0, frame_no = 0, ce_idx = 0;
    logic          e_hblk = 1'b1, e_vblk = 1'b1, e_hsyn = 1'b1, e_vsyn = 1'b1;
    logic          e_de = 1'b0, e_fs = 1'b0;
    logic [RW-1:0] e_rgb = '0;

    // observations gathered per test
    int mon_frame = -1, mon_line = 0;
    int hs_first, hs_cnt, hb_first, hb_cnt, vs_first, vs_cnt, fs_cnt, vs_fall_h;
    int fs_at[$];

    function automatic int clampi(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    task automatic clr();
        hs_first = -1; hs_cnt = 0; hb_first = -1; hb_cnt = 0;
        vs_first = -1; vs_cnt = 0; fs_cnt = 0; vs_fall_h = -1;
        fs_at.delete();
    endtask

    task automatic step(input bit ce_v);
        int h, v, f, fr, lines, hsb, vsb, q, w0;
        logic [RW-1:0] r;
        logic hb, vb, prev_vsyn, o_f1;
        logic [8:0] e_hpos;
        logic [36:0] obs, exp_v;
        h = mh; v = mv; f = mf1; fr = frame_no;
        r = RW'($urandom);
        ce = ce_v;
        core_rgb = r;
        prev_vsyn = vsyn;
        @(posedge clk_sys);
        @(negedge clk_sys);
        if (!reset_n) begin
            mh = 0; mv = 0; mf1 = 0; hl = 0; vl = 0; frame_no++;
            e_hblk = 1'b1; e_vblk = 1'b1; e_hsyn = 1'b1; e_vsyn = 1'b1;
            e_de = 1'b0; e_fs = 1'b0; e_rgb = '0;
        end else if (ce_v) begin
            hb = !(h >= HAB && h < HAB + HA);
            vb = !(v < VA);
            hsb = clampi(HSB + hl * HST, HAB + HA, HT - HSL);
            vsb = clampi(VSB + vl * VST, VA, VT - VSL);
            q = v * HT + h;
            w0 = vsb * HT + ((f != 0) ? HT / 2 : 0);
            e_hblk = hb;
            e_vblk = vb;
            e_hsyn = !(h >= hsb && h < hsb + HSL);
            e_vsyn = !(q >= w0 && q < w0 + VSL * HT);
            e_de = !(hb || vb);
            e_rgb = (hb || vb) ? '0 : r;
            e_fs = (h == 0 && v == 0);
            lines = VT + f;
            if (h == HT - 1 && v == lines - 1) begin
                hl = hoffs;
                vl = voffs;
                frame_no++;
`ifdef VTG_INTERLACE_EN
                mf1 = 1 - mf1;
`endif
            end
            mh = (h + 1) % HT;
            if (mh == 0) mv = (v + 1) % lines;
            ce_idx++;
            if (fr == mon_frame && v == mon_line) begin
                if (hsyn === 1'b0) begin
                    if (hs_cnt == 0) hs_first = h;
                    hs_cnt++;
                end
                if (hblk === 1'b0) begin
                    if (hb_cnt == 0) hb_first = h;
                    hb_cnt++;
                end
            end
            if (fr == mon_frame && h == 0 && vsyn === 1'b0) begin
                if (vs_cnt == 0) vs_first = v;
                vs_cnt++;
            end
            if (frame_start === 1'b1) begin
                fs_cnt++;
                fs_at.push_back(ce_idx);
            end
            if (prev_vsyn === 1'b1 && vsyn === 1'b0) vs_fall_h = h;
        end
        e_hpos = 9'((mh - HAB + 512) % 512);
`ifdef VTG_INTERLACE_EN
        o_f1 = f1;
`else
        o_f1 = 1'b0;
`endif
        obs   = {hpos, vpos, hblk, vblk, hsyn, vsyn, de, frame_start, o_f1, rgb};
        exp_v = {e_hpos, 9'(mv), e_hblk, e_vblk, e_hsyn, e_vsyn, e_de, e_fs, 1'(mf1), e_rgb};
        n_total++;
        if (obs !== exp_v) begin
            $display("FAIL outputs at h=%0d v=%0d ce=%0d: got %h expected %h", h, v, ce_v, obs, exp_v);
        end else begin
            n_pass++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(1'b1);
        step(1'b0);
        reset_n = 1'b1;
    endtask

    // gap < 0 selects a random 0..1 idle cycles before each CE
    task automatic run_ces(input int n, input int gap);
        int g;
        for (int i = 0; i < n; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 1)) : gap;
            for (int k = 0; k < g; k++) step(1'b0);
            step(1'b1);
        end
    endtask

    task automatic run_to_frame_end(input int gap);
        run_ces((VT + mf1 - mv) * HT - mh, gap);
    endtask

    task automatic test_reset();
        hoffs = '0; voffs = '0;
        do_reset();
        n_total++;
        if ({hblk, vblk, hsyn, vsyn, de, frame_start} !== 6'b111100 || rgb !== '0) begin
            $display("FAIL reset_outputs: got %b rgb=%h required 111100 rgb=0",
                     {hblk, vblk, hsyn, vsyn, de, frame_start}, rgb);
        end else n_pass++;
        n_total++;
        if (hpos !== 9'd496 || vpos !== 9'd0) begin
            $display("FAIL reset_pos: got hpos=%0d vpos=%0d required 496/0", hpos, vpos);
        end else n_pass++;
        step(1'b1);
        n_total++;
        if (frame_start !== 1'b1 || hblk !== 1'b1) begin
            $display("FAIL first_ce: got fs=%b hblk=%b required 1/1", frame_start, hblk);
        end else n_pass++;
    endtask

    task automatic test_default_frames();
        hoffs = '0; voffs = '0;
        do_reset();
        clr();
        mon_frame = frame_no; mon_line = 3;
        run_ces(2 * FR, 0);
        n_total++; if (hs_first !== 288) $display("FAIL hsync_begin: got %0d required 288", hs_first); else n_pass++;
        n_total++; if (hs_cnt !== HSL) $display("FAIL hsync_len: got %0d required %0d", hs_cnt, HSL); else n_pass++;
        n_total++; if (hb_first !== 16) $display("FAIL active_begin: got %0d required 16", hb_first); else n_pass++;
        n_total++; if (hb_cnt !== 256) $display("FAIL active_len: got %0d required 256", hb_cnt); else n_pass++;
        n_total++; if (vs_first !== VSB) $display("FAIL vsync_line: got %0d required %0d", vs_first, VSB); else n_pass++;
        n_total++; if (vs_cnt !== VSL) $display("FAIL vsync_len: got %0d required %0d", vs_cnt, VSL); else n_pass++;
        n_total++; if (fs_cnt !== 2) $display("FAIL frame_start_count: got %0d required 2", fs_cnt); else n_pass++;
        n_total++;
        if (fs_at.size() < 2 || fs_at[1] - fs_at[0] !== FR) begin
            $display("FAIL frame_length: got %0d required %0d", (fs_at.size() < 2) ? -1 : fs_at[1] - fs_at[0], FR);
        end else n_pass++;
    endtask

    task automatic test_offsets(input int ho, input int vo, input int exp_hs, input int exp_vs);
        hoffs = HOW'(ho); voffs = VOW'(vo);
        run_to_frame_end(0);
        clr();
        mon_frame = frame_no; mon_line = 2;
        run_to_frame_end(0);
        n_total++; if (hs_first !== exp_hs) $display("FAIL hoffs_%0d_begin: got %0d required %0d", ho, hs_first, exp_hs); else n_pass++;
        n_total++; if (hs_cnt !== HSL) $display("FAIL hoffs_%0d_len: got %0d required %0d", ho, hs_cnt, HSL); else n_pass++;
        n_total++; if (vs_first !== exp_vs) $display("FAIL voffs_%0d_line: got %0d required %0d", vo, vs_first, exp_vs); else n_pass++;
        n_total++; if (vs_cnt !== VSL) $display("FAIL voffs_%0d_len: got %0d required %0d", vo, vs_cnt, VSL); else n_pass++;
    endtask

    task automatic test_midframe_change();
        run_ces(5 * HT, -1);
        hoffs = -5;
        clr();
        mon_frame = frame_no; mon_line = 7;
        run_to_frame_end(-1);
        n_total++; if (hs_first !== 318) $display("FAIL midframe_old: got %0d required 318", hs_first); else n_pass++;
        clr();
        mon_frame = frame_no; mon_line = 1;
        run_ces(3 * HT, -1);
        n_total++; if (hs_first !== 278) $display("FAIL midframe_new: got %0d required 278", hs_first); else n_pass++;
        n_total++; if (hs_cnt !== HSL) $display("FAIL midframe_len: got %0d required %0d", hs_cnt, HSL); else n_pass++;
    endtask

    task automatic test_reset_midline();
        do_reset();
        run_ces(200, 7);
        n_total++; if (hpos !== 9'd184) $display("FAIL at_hcnt200: got hpos=%0d required 184", hpos); else n_pass++;
        reset_n = 1'b0;
        step(1'b1);
        n_total++;
        if ({hblk, vblk, hsyn, vsyn, de, frame_start} !== 6'b111100 || rgb !== '0 || hpos !== 9'd496) begin
            $display("FAIL midline_reset: got %b rgb=%h hpos=%0d required 111100 rgb=0 hpos=496",
                     {hblk, vblk, hsyn, vsyn, de, frame_start}, rgb, hpos);
        end else n_pass++;
        for (int i = 0; i < 3; i++) step(1'b0);
        reset_n = 1'b1;
        clr();
        mon_frame = frame_no; mon_line = 0;
        run_ces(400, 7);
        n_total++; if (hs_first !== 288) $display("FAIL reset_clears_offset: got %0d required 288", hs_first); else n_pass++;
    endtask

`ifdef VTG_INTERLACE_EN
    task automatic test_interlace();
        hoffs = '0; voffs = '0;
        do_reset();
        clr();
        run_to_frame_end(0);
        n_total++; if (f1 !== 1'b1) $display("FAIL f1_toggle: got %b required 1", f1); else n_pass++;
        vs_fall_h = -1;
        run_to_frame_end(0);
        run_ces(4, 0);
        n_total++; if (f1 !== 1'b0) $display("FAIL f1_back: got %b required 0", f1); else n_pass++;
        n_total++; if (vs_fall_h !== HT / 2) $display("FAIL odd_vsync_h: got %0d required %0d", vs_fall_h, HT / 2); else n_pass++;
        n_total++;
        if (fs_at.size() < 3 || fs_at[1] - fs_at[0] !== VT * HT || fs_at[2] - fs_at[1] !== (VT + 1) * HT) begin
            $display("FAIL field_lengths: got %0d pulses required %0d then %0d CE", fs_at.size(), VT * HT, (VT + 1) * HT);
        end else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_default_frames();
        test_offsets(-16, -4, 272, VA);
        test_offsets(15, 3, 318, VT - VSL);
        test_midframe_change();
        test_reset_midline();
`ifdef VTG_INTERLACE_EN
        test_interlace();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
